dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the RV32I core's load/store port. Accepts one request at a time over a
//  valid/ready handshake, inserts LATENCY wait cycles, and returns sign/zero-extended load data or a store ack.
//  Byte, half and word sizes with byte-lane writes; misaligned or out-of-range accesses return an error.
//  Sits between the core's data port and the system bus; memory is an internal word array.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words; must be a power of two
//  BASE_ADDR    32'h0000_2000 byte address of word 0; must be aligned to DEPTH_WORDS*4
//  LATENCY      2             wait cycles between accept and rsp_valid; range 0..15
// PORTS
//  clk          in   1   single clock
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept (high only in IDLE)
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_size     in   2   00 = byte, 01 = half, 10 = word (funct3[1:0]); 11 = error
//  req_unsigned in   1   zero-extend loads (funct3[2])
//  req_wdata    in   32  store data, right-aligned
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer takes the response
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_err      out  1   misaligned, size 11, or out-of-range access
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low.
//  - Reset values: FSM = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
//    RAM contents are not reset.
//  - FSM states: IDLE -> WAIT -> RESP -> IDLE.
//    IDLE:
//      - A request is accepted when req_valid && req_ready. Address, size, we, unsigned and wdata are latched.
//      - Goes to WAIT with count = LATENCY; goes directly to RESP when LATENCY = 0.
//    WAIT:
//      - count decrements each cycle. At count == 1 the memory access is performed and the FSM enters RESP.
//    RESP:
//      - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
//      - On rsp_valid && rsp_ready, go to IDLE. req_ready rises the following cycle: no accept in a handshake cycle.
//  - Latency: accept in cycle N gives rsp_valid in cycle N+LATENCY+1. Maximum throughput is one request per LATENCY+2 cycles.
//  - Error cases:
//    - Half access with addr[0] = 1, word access with addr[1:0] != 0, size 11, or addr outside
//      [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4) sets rsp_err = 1.
//    - An errored access performs no write and returns rsp_rdata = 0.
//  - Stores:
//    - Byte enables are derived from size and addr[1:0].
//    - wdata is replicated into lanes: byte -> {4{b}}, half -> {2{h}}.
//    - The store commits on the cycle the FSM enters RESP.
//  - Loads:
//    - The lane is selected by addr[1:0].
//    - Sign-extended unless req_unsigned. A word load ignores req_unsigned.
//  - Word index = (addr - BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits.
//  - Request inputs are ignored outside IDLE; changes while req_ready = 0 have no effect.
//  - Reset asserted mid-transaction aborts it. A store that has not reached its commit edge is not written.
// CONFIGURATION
//  - DMEM_MMIO_EN defined:
//    - Adds ports tohost_valid (out, 1) and tohost_data (out, 32).
//    - A word store to 32'hFFFF_FFF0 sets tohost_data and pulses tohost_valid for one cycle at commit.
//      RAM is not written and rsp_err = 0.
//    - Loads from that address return tohost_data.
//    - Both ports reset to 0.
//  - DMEM_MMIO_EN undefined: no ports are added, and 32'hFFFF_FFF0 is out of range (rsp_err = 1).
// STRUCTURE
//  - riscv_pkg:
//    - mem_size_t enum (MEM_B, MEM_H, MEM_W)
//    - dmem_state_t enum (IDLE, WAIT, RESP)
//    - TOHOST_ADDR constant
//  - Sub-module dmem_ram:
//    - DEPTH_WORDS x 32 array, 4-bit byte-enable synchronous write, combinational read.
//    - Instantiated once.
//  - Lane steering, extension, FSM and error checks live in dmem_responder.
// TESTING
//  1. Reset with LATENCY=2: req_ready=1, rsp_valid=0. Then store word 0xDEADBEEF @0x2000, accepted at cycle N
//     -> rsp_valid at N+3, rsp_err=0.
//  2. Load byte @0x2003, signed -> rsp_rdata=0xFFFFFFDE. Same with req_unsigned=1 -> 0x000000DE.
//     Load half @0x2002 signed -> 0xFFFFDEAD.
//  3. Store byte 0x12 @0x2001, then load word @0x2000 -> 0xDEAD12EF.
//     Store half @0x2001 -> rsp_err=1; word unchanged.
//  4. Load @0x1FFC or @0x3000 (DEPTH 1024) -> rsp_err=1, rsp_rdata=0.
//     req_size=11 -> rsp_err=1.
//  5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable and req_ready=0 throughout.
//     Pulse reset low during WAIT of a store -> FSM is IDLE and a later load shows the old data.
//  6. With DMEM_MMIO_EN, store word 0x1 @0xFFFFFFF0 -> tohost_valid pulses once and tohost_data=1.
//     Without DMEM_MMIO_EN, the same store -> rsp_err=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I data-memory responder.
package riscv_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dmem_state_t;

   localparam logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0;

   // Byte-lane enables for a store of the given size at byte offset lo.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         MEM_B:   be = 4'b0001 << lo;
         MEM_H:   be = lo[1] ? 4'b1100 : 4'b0011;
         MEM_W:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: byte-enable synchronous write, combinational read, no reset.
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [3:0]                     be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with LATENCY wait cycles, lane steering and error checks.
// Optional tohost MMIO register enabled by defining DMEM_MMIO_EN.
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
   parameter int          LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
`ifdef DMEM_MMIO_EN
   ,
   output logic        tohost_valid,
   output logic [31:0] tohost_data
`endif
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_t state, state_nx;
   logic [3:0]  count, count_nx;
   logic        accept, commit;

   logic [31:0] l_addr, l_wdata;
   logic [1:0]  l_size;
   logic        l_we, l_uns;

   // The access is evaluated on the edge entering RESP; with LATENCY=0 that edge
   // is the accept edge itself, so the live request is used while in IDLE.
   logic [31:0] a_addr, a_wdata;
   logic [1:0]  a_size;
   logic        a_we, a_uns;

   logic [31:0] offset, wdata_rep, ram_rdata, lane, load_val, rd_val;
   logic [AW-1:0] ram_idx;
   logic [3:0]  be;
   logic        in_range, misaligned, bad_size, mmio_hit, err, ram_we;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_nx = state;
      count_nx = count;
      commit   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_nx = RESP;
                  commit   = 1'b1;
               end else begin
                  state_nx = WAIT;
                  count_nx = 4'(LATENCY);
               end
            end
         end
         WAIT: begin
            if (count == 4'd1) begin
               state_nx = RESP;
               commit   = 1'b1;
               count_nx = 4'd0;
            end else begin
               count_nx = count - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      if (state == IDLE) begin
         a_addr  = req_addr;
         a_wdata = req_wdata;
         a_size  = req_size;
         a_we    = req_we;
         a_uns   = req_unsigned;
      end else begin
         a_addr  = l_addr;
         a_wdata = l_wdata;
         a_size  = l_size;
         a_we    = l_we;
         a_uns   = l_uns;
      end
   end

   always_comb begin
      offset     = a_addr - BASE_ADDR;
      in_range   = ((offset >> (AW + 2)) == 32'd0);
      ram_idx    = offset[AW+1:2];
      bad_size   = (a_size == 2'b11);
      misaligned = ((a_size == MEM_H) && a_addr[0]) ||
                   ((a_size == MEM_W) && (a_addr[1:0] != 2'b00));
`ifdef DMEM_MMIO_EN
      mmio_hit   = (a_addr == TOHOST_ADDR) && (a_size == MEM_W);
`else
      mmio_hit   = 1'b0;
`endif
      err        = bad_size || misaligned || (!in_range && !mmio_hit);
      be         = byte_en(a_size, a_addr[1:0]);
      ram_we     = commit && a_we && !err && !mmio_hit;
   end

   always_comb begin
      case (a_size)
         MEM_B:   wdata_rep = {4{a_wdata[7:0]}};
         MEM_H:   wdata_rep = {2{a_wdata[15:0]}};
         default: wdata_rep = a_wdata;
      endcase
   end

   always_comb begin
      lane = ram_rdata >> {a_addr[1:0], 3'b000};
      case (a_size)
         MEM_B:   load_val = a_uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         MEM_H:   load_val = a_uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_val = ram_rdata;
      endcase
`ifdef DMEM_MMIO_EN
      if (mmio_hit) load_val = tohost_data;
`endif
      rd_val = (a_we || err) ? 32'd0 : load_val;
   end

   dmem_ram #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (be),
      .addr  (ram_idx),
      .wdata (wdata_rep),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= 4'd0;
         l_addr    <= 32'd0;
         l_wdata   <= 32'd0;
         l_size    <= 2'b00;
         l_we      <= 1'b0;
         l_uns     <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         if (accept) begin
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_size  <= req_size;
            l_we    <= req_we;
            l_uns   <= req_unsigned;
         end
         if (commit) begin
            rsp_rdata <= rd_val;
            rsp_err   <= err;
         end
      end
   end

`ifdef DMEM_MMIO_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tohost_valid <= 1'b0;
         tohost_data  <= 32'd0;
      end else begin
         tohost_valid <= 1'b0;
         if (commit && a_we && mmio_hit) begin
            tohost_valid <= 1'b1;
            tohost_data  <= a_wdata;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024, base 0x2000).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_MMIO_EN
   logic        tohost_valid;
   logic [31:0] tohost_data;
   int          tohost_cnt = 0;
`endif

   int          checks = 0;
   int          failures = 0;
   logic [31:0] r_rdata;
   logic        r_err;
   int          r_lat;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_2000),
      .LATENCY     (2)
   ) dut (
      .clk          (clk),
      .reset        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
`ifdef DMEM_MMIO_EN
      ,
      .tohost_valid (tohost_valid),
      .tohost_data  (tohost_data)
`endif
   );

`ifdef DMEM_MMIO_EN
   always @(negedge clk) if (tohost_valid) tohost_cnt++;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge, scramble the inputs once accepted,
   // then count falling edges until rsp_valid and capture the response.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = ~we; req_addr = 32'h0000_2FFC;
      req_size = 2'b10; req_unsigned = ~uns; req_wdata = 32'hA5A5_A5A5;
      r_lat = 0;
      do begin
         @(negedge clk);
         r_lat++;
      end while (!rsp_valid && r_lat < 20);
      if (r_lat >= 20) check("rsp_timeout", 32'd1, 32'd0);
      r_rdata = rsp_rdata;
      r_err   = rsp_err;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
      issue(we, addr, size, uns, wdata);
      finish_rsp();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
      rst_n = 1'b1;

      // store word, latency accept->rsp_valid is LATENCY+1 edges
      xact(1'b1, 32'h0000_2000, 2'b10, 1'b0, 32'hDEAD_BEEF);
      check("sw_latency", r_lat, 32'd3);
      check("sw_err",     {31'd0, r_err}, 32'd0);
      check("sw_rdata",   r_rdata, 32'd0);
      @(negedge clk);
      check("ready_after_hs", {31'd0, req_ready}, 32'd1);

      xact(1'b0, 32'h0000_2003, 2'b00, 1'b0, 32'd0);
      check("lb_signed",   r_rdata, 32'hFFFF_FFDE);
      xact(1'b0, 32'h0000_2003, 2'b00, 1'b1, 32'd0);
      check("lbu",         r_rdata, 32'h0000_00DE);
      xact(1'b0, 32'h0000_2002, 2'b01, 1'b0, 32'd0);
      check("lh_signed",   r_rdata, 32'hFFFF_DEAD);
      xact(1'b0, 32'h0000_2000, 2'b01, 1'b1, 32'd0);
      check("lhu_low",     r_rdata, 32'h0000_BEEF);

      xact(1'b1, 32'h0000_2001, 2'b00, 1'b0, 32'h0000_0012);
      check("sb_err",      {31'd0, r_err}, 32'd0);
      xact(1'b0, 32'h0000_2000, 2'b10, 1'b0, 32'd0);
      check("lw_after_sb", r_rdata, 32'hDEAD_12EF);
      xact(1'b1, 32'h0000_2001, 2'b01, 1'b0, 32'h0000_7777);
      check("sh_misalign_err", {31'd0, r_err}, 32'd1);
      xact(1'b0, 32'h0000_2000, 2'b10, 1'b0, 32'd0);
      check("lw_after_bad_sh", r_rdata, 32'hDEAD_12EF);
      xact(1'b0, 32'h0000_2002, 2'b10, 1'b0, 32'd0);
      check("lw_misalign_err",   {31'd0, r_err}, 32'd1);
      check("lw_misalign_rdata", r_rdata, 32'd0);

      // last word in range and byte lane from it
      xact(1'b1, 32'h0000_2FFC, 2'b10, 1'b0, 32'h1122_3344);
      check("sw_top_err", {31'd0, r_err}, 32'd0);
      xact(1'b0, 32'h0000_2FFC, 2'b10, 1'b0, 32'd0);
      check("lw_top",     r_rdata, 32'h1122_3344);
      xact(1'b0, 32'h0000_2FFD, 2'b00, 1'b1, 32'd0);
      check("lbu_top",    r_rdata, 32'h0000_0033);

      xact(1'b0, 32'h0000_1FFC, 2'b10, 1'b0, 32'd0);
      check("below_err",   {31'd0, r_err}, 32'd1);
      check("below_rdata", r_rdata, 32'd0);
      xact(1'b0, 32'h0000_3000, 2'b10, 1'b0, 32'd0);
      check("above_err",   {31'd0, r_err}, 32'd1);
      check("above_rdata", r_rdata, 32'd0);
      xact(1'b1, 32'h0000_3000, 2'b10, 1'b0, 32'h9999_9999);
      check("sw_above_err", {31'd0, r_err}, 32'd1);
      xact(1'b0, 32'h0000_2000, 2'b10, 1'b0, 32'd0);
      check("lw_no_alias", r_rdata, 32'hDEAD_12EF);
      xact(1'b0, 32'h0000_2000, 2'b11, 1'b0, 32'd0);
      check("size11_err",  {31'd0, r_err}, 32'd1);

      // backpressure: response held stable, no accept while in RESP
      issue(1'b0, 32'h0000_2000, 2'b10, 1'b0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_rdata", rsp_rdata, 32'hDEAD_12EF);
         check("hold_ready", {31'd0, req_ready}, 32'd0);
      end
      finish_rsp();

      // reset during WAIT of a store aborts it before the commit edge
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_2000;
      req_size = 2'b10; req_wdata = 32'h5555_5555;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      check("abort_valid", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b1;
      xact(1'b0, 32'h0000_2000, 2'b10, 1'b0, 32'd0);
      check("abort_no_write", r_rdata, 32'hDEAD_12EF);

`ifdef DMEM_MMIO_EN
      xact(1'b1, 32'hFFFF_FFF0, 2'b10, 1'b0, 32'h0000_0001);
      repeat (2) @(negedge clk);
      check("mmio_err",    {31'd0, r_err}, 32'd0);
      check("mmio_pulses", tohost_cnt, 32'd1);
      check("mmio_data",   tohost_data, 32'd1);
      xact(1'b0, 32'hFFFF_FFF0, 2'b10, 1'b0, 32'd0);
      check("mmio_load",   r_rdata, 32'd1);
`else
      xact(1'b1, 32'hFFFF_FFF0, 2'b10, 1'b0, 32'h0000_0001);
      check("tohost_oor_err", {31'd0, r_err}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
